// File: rtl/riscv_fetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, issues in-order imem requests
// under a credit limit and buffers {pc, instr} pairs for decode.
module riscv_fetch_unit #(
    parameter int              XLEN       = 32,
    parameter int              ILEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int              FBUF_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            fetch_en,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [ILEN-1:0] imem_rsp_data,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [ILEN-1:0] instr_data,
    output logic [XLEN-1:0] instr_pc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc
);

    localparam int PTR_W = (FBUF_DEPTH > 1) ? $clog2(FBUF_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FBUF_DEPTH);

    // Handshakes: a transfer happens on a rising clk edge where valid & ready are
    // both high; the response channel has no ready and every valid is consumed.
    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] r_resp_pc;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_outstanding;
    logic [CNT_W-1:0] r_drop_cnt;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [ILEN-1:0]  r_buf_data [FBUF_DEPTH];
    logic [XLEN-1:0]  r_buf_pc   [FBUF_DEPTH];

    logic [CNT_W:0]   w_occupancy;
    logic             w_credit;
    logic             w_req_fire;
    logic             w_push;
    logic             w_pop;
    logic [XLEN-1:0]  w_target;
    logic             w_unused_redirect_lsb;
    logic [CNT_W-1:0] w_outstanding_nxt;
    logic [CNT_W-1:0] w_drop_cnt_nxt;
    logic [CNT_W-1:0] w_count_nxt;
    logic [XLEN-1:0]  w_fetch_pc_nxt;
    logic [XLEN-1:0]  w_resp_pc_nxt;

    // Buffered plus in-flight entries never exceed the buffer size, so a
    // response always has a free slot.
    assign w_occupancy = {1'b0, r_count} + {1'b0, r_outstanding};
    assign w_credit    = w_occupancy < {1'b0, DEPTH_C};

    assign w_target              = {redirect_pc[XLEN-1:2], 2'b00};
    assign w_unused_redirect_lsb = ^redirect_pc[1:0];

    // rst_n gates the request so the port reads idle for the whole reset window.
    assign imem_req_valid = rst_n & fetch_en & w_credit & ~redirect_valid;
    assign imem_req_addr  = r_fetch_pc;
    assign instr_valid    = (r_count != '0) & ~redirect_valid;
    assign instr_data     = r_buf_data[r_rd_ptr];
    assign instr_pc       = r_buf_pc[r_rd_ptr];

    assign w_req_fire = imem_req_valid & imem_req_ready;
    assign w_push     = imem_rsp_valid & (r_drop_cnt == '0) & ~redirect_valid;
    assign w_pop      = instr_valid & instr_ready;

    always_comb begin
        w_outstanding_nxt = r_outstanding + CNT_W'(w_req_fire) - CNT_W'(imem_rsp_valid);
        w_drop_cnt_nxt    = r_drop_cnt;
        w_count_nxt       = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        w_fetch_pc_nxt    = r_fetch_pc;
        w_resp_pc_nxt     = r_resp_pc;
        if (w_req_fire) begin
            w_fetch_pc_nxt = r_fetch_pc + XLEN'(4);
        end
        if (w_push) begin
            w_resp_pc_nxt = r_resp_pc + XLEN'(4);
        end
        if (imem_rsp_valid && (r_drop_cnt != '0)) begin
            w_drop_cnt_nxt = r_drop_cnt - CNT_W'(1);
        end
        // Every request still in flight at a redirect belongs to the old path.
        if (redirect_valid) begin
            w_count_nxt    = '0;
            w_drop_cnt_nxt = w_outstanding_nxt;
            w_fetch_pc_nxt = w_target;
            w_resp_pc_nxt  = w_target;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc    <= RESET_PC;
            r_resp_pc     <= RESET_PC;
            r_count       <= '0;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            for (int i = 0; i < FBUF_DEPTH; i++) begin
                r_buf_data[i] <= '0;
                r_buf_pc[i]   <= '0;
            end
        end else begin
            r_fetch_pc    <= w_fetch_pc_nxt;
            r_resp_pc     <= w_resp_pc_nxt;
            r_count       <= w_count_nxt;
            r_outstanding <= w_outstanding_nxt;
            r_drop_cnt    <= w_drop_cnt_nxt;
            if (redirect_valid) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_push) begin
                    r_buf_data[r_wr_ptr] <= imem_rsp_data;
                    r_buf_pc[r_wr_ptr]   <= r_resp_pc;
                    r_wr_ptr             <= r_wr_ptr + PTR_W'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                end
            end
        end
    end

`ifndef SYNTHESIS
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(imem_rsp_valid && (r_drop_cnt == '0) && (r_count == DEPTH_C)));
    a_rsp_has_request: assert property (@(posedge clk) disable iff (!rst_n)
        !(imem_rsp_valid && (r_outstanding == '0)));
`endif

endmodule

// File: tb/tb_riscv_fetch_unit.sv
// Bench for riscv_fetch_unit: in-order random-latency memory, epoch-tagged
// reference model of the delivered PC stream, and per-scenario tasks.
module tb_riscv_fetch_unit;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        fetch_en, req_valid, req_ready, rsp_valid;
    logic [31:0] req_addr, rsp_data;
    logic        instr_valid, instr_ready, redirect_valid;
    logic [31:0] instr_data, instr_pc, redirect_pc;

    logic        wp_fetch_en, wp_req_valid, wp_instr_valid;
    logic [31:0] wp_req_addr, wp_instr_data, wp_instr_pc;
    logic        wp_zero_bit = 1'b0;
    logic        wp_one_bit = 1'b1;
    logic [31:0] wp_zero_word = 32'h0;

    always #5 clk = ~clk;

    riscv_fetch_unit #(.XLEN(32), .ILEN(32), .RESET_PC(32'h0), .FBUF_DEPTH(DEPTH)) u_dut (
        .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en),
        .imem_req_valid(req_valid), .imem_req_ready(req_ready), .imem_req_addr(req_addr),
        .imem_rsp_valid(rsp_valid), .imem_rsp_data(rsp_data),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_data(instr_data), .instr_pc(instr_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    riscv_fetch_unit #(.XLEN(32), .ILEN(32), .RESET_PC(32'hFFFF_FFF8), .FBUF_DEPTH(DEPTH)) u_dut_wrap (
        .clk(clk), .rst_n(rst_n), .fetch_en(wp_fetch_en),
        .imem_req_valid(wp_req_valid), .imem_req_ready(wp_one_bit), .imem_req_addr(wp_req_addr),
        .imem_rsp_valid(wp_zero_bit), .imem_rsp_data(wp_zero_word),
        .instr_valid(wp_instr_valid), .instr_ready(wp_zero_bit),
        .instr_data(wp_instr_data), .instr_pc(wp_instr_pc),
        .redirect_valid(wp_zero_bit), .redirect_pc(wp_zero_word)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
    } mreq_t;

    mreq_t       mem_q[$];
    mreq_t       cur_rsp;
    logic [31:0] exp_q[$];
    logic [31:0] m_fetch_pc;
    int          m_epoch, cyc, mem_last_due, lat_min, lat_max;

    logic        s_req_valid, s_exp_req_valid, s_valid, s_exp_valid;
    logic        s_fire, s_pop, s_pop_known;
    logic [31:0] s_fire_addr, s_exp_addr, s_pop_pc, s_pop_data, s_exp_pc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0F0F;
    endfunction

    task automatic model_reset();
        mem_q.delete();
        exp_q.delete();
        m_fetch_pc   = 32'h0;
        m_epoch      = 0;
        cyc          = 0;
        mem_last_due = 0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        fetch_en = 1'b0; req_ready = 1'b0; instr_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 32'h0;
        rsp_valid = 1'b0; rsp_data = 32'h0; wp_fetch_en = 1'b0;
        lat_min = 1; lat_max = 1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // One clock cycle: memory drives its response, outputs are sampled mid-cycle,
    // and the reference model advances to what the next edge commits.
    task automatic step();
        bit has_rsp;
        int occ, due;
        has_rsp = 0;
        if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
            cur_rsp   = mem_q.pop_front();
            has_rsp   = 1;
            rsp_valid = 1'b1;
            rsp_data  = mem_word(cur_rsp.addr);
        end else begin
            rsp_valid = 1'b0;
            rsp_data  = $urandom();
        end
        occ = exp_q.size() + mem_q.size() + (has_rsp ? 1 : 0);
        @(negedge clk);
        s_exp_req_valid = fetch_en && !redirect_valid && (occ < DEPTH);
        s_exp_valid     = (exp_q.size() != 0) && !redirect_valid;
        s_req_valid     = req_valid;
        s_valid         = instr_valid;
        s_fire          = req_valid && req_ready;
        s_fire_addr     = req_addr;
        s_exp_addr      = m_fetch_pc;
        s_pop           = instr_valid && instr_ready;
        s_pop_known     = 1'b0;
        s_pop_pc        = instr_pc;
        s_pop_data      = instr_data;
        s_exp_pc        = 32'hDEAD_BEEF;
        if (s_pop && exp_q.size() != 0) begin
            s_pop_known = 1'b1;
            s_exp_pc    = exp_q.pop_front();
        end
        if (has_rsp && !redirect_valid && cur_rsp.epoch == m_epoch) exp_q.push_back(cur_rsp.addr);
        if (s_fire) begin
            due = cyc + $urandom_range(lat_min, lat_max);
            if (due < mem_last_due) due = mem_last_due;
            mem_last_due = due;
            mem_q.push_back('{addr: req_addr, epoch: m_epoch, due: due});
            m_fetch_pc = m_fetch_pc + 32'd4;
        end
        if (redirect_valid) begin
            m_epoch++;
            m_fetch_pc = {redirect_pc[31:2], 2'b00};
            exp_q.delete();
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #2;
        rst_n = 1'b0;
        fetch_en = 1'b1; req_ready = 1'b1; instr_ready = 1'b1;
        redirect_valid = 1'b0; redirect_pc = 32'h0;
        rsp_valid = 1'b0; rsp_data = 32'h0; wp_fetch_en = 1'b1;
        #2;
        checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid got %b exp 0", req_valid); end
        checks++; if (req_addr !== 32'h0) begin errors++; $display("FAIL reset_req_addr got %h exp 0", req_addr); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_instr_valid got %b exp 0", instr_valid); end
        checks++; if (instr_data !== 32'h0) begin errors++; $display("FAIL reset_instr_data got %h exp 0", instr_data); end
        checks++; if (instr_pc !== 32'h0) begin errors++; $display("FAIL reset_instr_pc got %h exp 0", instr_pc); end
        checks++; if (wp_req_addr !== 32'hFFFF_FFF8) begin errors++; $display("FAIL reset_wrap_addr got %h exp fffffff8", wp_req_addr); end
        checks++; if (wp_req_valid !== 1'b0) begin errors++; $display("FAIL reset_wrap_valid got %b exp 0", wp_req_valid); end
    endtask

    task automatic test_stream();
        logic [31:0] first_pcs [4];
        int pops = 0;
        int first_cyc = -1;
        int late_pops = 0;
        do_reset();
        fetch_en = 1'b1; req_ready = 1'b1; instr_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            checks++;
            if (s_valid !== s_exp_valid) begin errors++; $display("FAIL stream_valid cyc %0d got %b exp %b", i, s_valid, s_exp_valid); end
            if (s_pop) begin
                checks++;
                if (!s_pop_known || s_pop_pc !== s_exp_pc || s_pop_data !== mem_word(s_exp_pc)) begin
                    errors++; $display("FAIL stream_pop pc %h data %h exp pc %h data %h", s_pop_pc, s_pop_data, s_exp_pc, mem_word(s_exp_pc));
                end
                if (pops < 4) first_pcs[pops] = s_pop_pc;
                if (pops == 0) first_cyc = i;
                if (i >= 10) late_pops++;
                pops++;
            end
        end
        for (int j = 0; j < 4; j++) begin
            checks++;
            if (pops <= j || first_pcs[j] !== 32'(j * 4)) begin
                errors++; $display("FAIL stream_pc_seq idx %0d got %h exp %h", j, first_pcs[j], 32'(j * 4));
            end
        end
        checks++; if (first_cyc != 2) begin errors++; $display("FAIL stream_latency got %0d exp 2", first_cyc); end
        checks++; if (late_pops != 10) begin errors++; $display("FAIL stream_throughput got %0d exp 10", late_pops); end
    endtask

    task automatic test_backpressure();
        int fires = 0;
        logic [31:0] last_addr = 32'h0;
        do_reset();
        fetch_en = 1'b1; req_ready = 1'b1; instr_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (s_fire) fires++;
        end
        checks++; if (fires != 4) begin errors++; $display("FAIL bp_req_count got %0d exp 4", fires); end
        checks++; if (s_req_valid !== 1'b0) begin errors++; $display("FAIL bp_req_stall got %b exp 0", s_req_valid); end
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        checks++;
        if (!s_pop || s_pop_pc !== 32'h0 || s_pop_data !== mem_word(32'h0)) begin
            errors++; $display("FAIL bp_pop pop %b pc %h data %h exp pc 0", s_pop, s_pop_pc, s_pop_data);
        end
        fires = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (s_fire) begin fires++; last_addr = s_fire_addr; end
        end
        checks++; if (fires != 1) begin errors++; $display("FAIL bp_refill_count got %0d exp 1", fires); end
        checks++; if (last_addr !== 32'h10) begin errors++; $display("FAIL bp_refill_addr got %h exp 10", last_addr); end
    endtask

    // Run after a redirect: first request and first delivered PC must both be tgt.
    task automatic redirect_follow(input string name, input logic [31:0] tgt);
        logic [31:0] first_fire = 32'hDEAD_BEEF;
        logic [31:0] first_pop = 32'hDEAD_BEEF;
        for (int i = 0; i < 14; i++) begin
            step();
            if (s_fire && first_fire === 32'hDEAD_BEEF) first_fire = s_fire_addr;
            if (s_pop) begin
                if (first_pop === 32'hDEAD_BEEF) first_pop = s_pop_pc;
                checks++;
                if (!s_pop_known || s_pop_pc !== s_exp_pc || s_pop_data !== mem_word(s_exp_pc)) begin
                    errors++; $display("FAIL %s_pop pc %h data %h exp pc %h", name, s_pop_pc, s_pop_data, s_exp_pc);
                end
            end
        end
        checks++; if (first_fire !== tgt) begin errors++; $display("FAIL %s_first_req got %h exp %h", name, first_fire, tgt); end
        checks++; if (first_pop !== tgt) begin errors++; $display("FAIL %s_first_pc got %h exp %h", name, first_pop, tgt); end
    endtask

    task automatic test_redirect();
        do_reset();
        fetch_en = 1'b1; req_ready = 1'b1; instr_ready = 1'b1;
        lat_min = 3; lat_max = 3;
        step();
        step();
        redirect_valid = 1'b1; redirect_pc = 32'h103;
        step();
        redirect_valid = 1'b0;
        checks++; if (s_req_valid !== 1'b0) begin errors++; $display("FAIL redir_req_valid got %b exp 0", s_req_valid); end
        checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL redir_instr_valid got %b exp 0", s_valid); end
        redirect_follow("redir", 32'h100);
    endtask

    task automatic test_redirect_rsp();
        do_reset();
        fetch_en = 1'b1; req_ready = 1'b1; instr_ready = 1'b1;
        lat_min = 2; lat_max = 2;
        step();
        fetch_en = 1'b0;
        step();
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        step();
        redirect_valid = 1'b0;
        fetch_en = 1'b1;
        redirect_follow("redir_rsp", 32'h200);
    endtask

    task automatic test_back_to_back();
        do_reset();
        fetch_en = 1'b1; req_ready = 1'b1; instr_ready = 1'b1;
        lat_min = 3; lat_max = 3;
        repeat (3) step();
        redirect_valid = 1'b1; redirect_pc = 32'h300;
        step();
        redirect_pc = 32'h402;
        step();
        redirect_valid = 1'b0;
        redirect_follow("b2b", 32'h400);
    endtask

    task automatic test_wrap();
        logic [31:0] addrs[$];
        logic [31:0] exp_addrs [4];
        exp_addrs[0] = 32'hFFFF_FFF8; exp_addrs[1] = 32'hFFFF_FFFC;
        exp_addrs[2] = 32'h0000_0000; exp_addrs[3] = 32'h0000_0004;
        do_reset();
        wp_fetch_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (wp_req_valid) addrs.push_back(wp_req_addr);
            @(posedge clk);
            #1;
        end
        wp_fetch_en = 1'b0;
        checks++; if (addrs.size() != 4) begin errors++; $display("FAIL wrap_req_count got %0d exp 4", addrs.size()); end
        for (int j = 0; j < 4; j++) begin
            checks++;
            if (addrs.size() <= j || addrs[j] !== exp_addrs[j]) begin
                errors++; $display("FAIL wrap_addr idx %0d got %h exp %h", j, (addrs.size() > j) ? addrs[j] : 32'hDEAD_BEEF, exp_addrs[j]);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        fetch_en = 1'b1; req_ready = 1'b1; instr_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            lat_min = (i < 2) ? 1 : 8; lat_max = lat_min;
            step();
        end
        checks++;
        if (instr_valid !== 1'b1 || instr_data !== mem_word(32'h0)) begin
            errors++; $display("FAIL rmid_pre valid %b data %h exp 1 %h", instr_valid, instr_data, mem_word(32'h0));
        end
        rst_n = 1'b0;
        rsp_valid = 1'b0;
        #1;
        checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL rmid_req_valid got %b exp 0", req_valid); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rmid_instr_valid got %b exp 0", instr_valid); end
        checks++; if (instr_data !== 32'h0) begin errors++; $display("FAIL rmid_instr_data got %h exp 0", instr_data); end
        checks++; if (instr_pc !== 32'h0) begin errors++; $display("FAIL rmid_instr_pc got %h exp 0", instr_pc); end
        checks++; if (req_addr !== 32'h0) begin errors++; $display("FAIL rmid_req_addr got %h exp 0", req_addr); end
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        instr_ready = 1'b1;
        lat_min = 1; lat_max = 1;
        redirect_follow("rmid", 32'h0);
    endtask

    task automatic test_random();
        do_reset();
        lat_min = 1; lat_max = 4;
        for (int i = 0; i < 800; i++) begin
            fetch_en    = ($urandom_range(0, 9) < 8);
            req_ready   = ($urandom_range(0, 3) != 0);
            instr_ready = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 24) == 0) || (redirect_valid && $urandom_range(0, 1) == 1);
            redirect_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom();
            step();
            checks++;
            if (s_req_valid !== s_exp_req_valid) begin errors++; $display("FAIL rand_req_valid cyc %0d got %b exp %b", i, s_req_valid, s_exp_req_valid); end
            checks++;
            if (s_valid !== s_exp_valid) begin errors++; $display("FAIL rand_instr_valid cyc %0d got %b exp %b", i, s_valid, s_exp_valid); end
            if (s_fire) begin
                checks++;
                if (s_fire_addr !== s_exp_addr) begin errors++; $display("FAIL rand_req_addr cyc %0d got %h exp %h", i, s_fire_addr, s_exp_addr); end
            end
            if (s_pop) begin
                checks++;
                if (!s_pop_known || s_pop_pc !== s_exp_pc || s_pop_data !== mem_word(s_exp_pc)) begin
                    errors++; $display("FAIL rand_pop cyc %0d pc %h data %h exp pc %h", i, s_pop_pc, s_pop_data, s_exp_pc);
                end
            end
        end
        redirect_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_redirect_rsp();
        test_back_to_back();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
